// File: rtl/dmem_arbiter_if.sv
// Request/response bundle shared by the two requesters, the arbiter and the data memory.
// slave = arbiter side, master = requesters plus memory.
interface dmem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              p0_req;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata;
    logic              p0_we;
    logic [3:0]        p0_sign_mask;
    logic              p0_ack;
    logic [DATA_W-1:0] p0_rdata;

    logic              p1_req;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata;
    logic              p1_we;
    logic [3:0]        p1_sign_mask;
    logic              p1_ack;
    logic [DATA_W-1:0] p1_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_write_data;
    logic              mem_memread;
    logic              mem_memwrite;
    logic [3:0]        mem_sign_mask;
    logic [DATA_W-1:0] mem_read_data;
    logic              mem_clk_stall;

    logic              busy;
    logic              err;

    modport slave (
        input  p0_req, p0_addr, p0_wdata, p0_we, p0_sign_mask,
        input  p1_req, p1_addr, p1_wdata, p1_we, p1_sign_mask,
        input  mem_read_data, mem_clk_stall,
        output p0_ack, p0_rdata, p1_ack, p1_rdata,
        output mem_addr, mem_write_data, mem_memread, mem_memwrite, mem_sign_mask,
        output busy, err
    );

    modport master (
        output p0_req, p0_addr, p0_wdata, p0_we, p0_sign_mask,
        output p1_req, p1_addr, p1_wdata, p1_we, p1_sign_mask,
        output mem_read_data, mem_clk_stall,
        input  p0_ack, p0_rdata, p1_ack, p1_rdata,
        input  mem_addr, mem_write_data, mem_memread, mem_memwrite, mem_sign_mask,
        input  busy, err
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter and stall-handshake sequencer in front of the data memory.
// Optional stall watchdog is built in when DMEM_ARB_TIMEOUT_EN is defined.
module dmem_arbiter #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_WAIT = 15
) (
    input logic           clk,
    input logic           reset,
    dmem_arbiter_if.slave bus
);

    typedef enum logic [2:0] {StIdle, StIssue, StStallHi, StStallLo, StResp} state_e;

    state_e            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              win_q, win_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic [3:0]        mask_q, mask_d;
    logic [DATA_W-1:0] cap_d;
    logic              timeout_d;

    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_rd_q, mem_rd_d;
    logic              mem_wr_q, mem_wr_d;
    logic [3:0]        mem_mask_q, mem_mask_d;
    logic [1:0]        ack_q, ack_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;

`ifdef DMEM_ARB_TIMEOUT_EN
    localparam int unsigned WdW = ($clog2(MAX_WAIT + 1) > 4) ? $clog2(MAX_WAIT + 1) : 4;
    logic [WdW-1:0] wdog_q, wdog_d;
    logic           wd_expire;
    // Counter reads 0 in the first STALL_HI cycle, so expiry lands MAX_WAIT cycles after entry.
    assign wd_expire = (wdog_q == WdW'(MAX_WAIT - 1));
`else
    logic unused_max_wait;
    assign unused_max_wait = ^MAX_WAIT;
`endif

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        win_d        = win_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        we_d         = we_q;
        mask_d       = mask_q;
        cap_d        = '0;
        timeout_d    = 1'b0;
`ifdef DMEM_ARB_TIMEOUT_EN
        wdog_d       = wdog_q;
`endif
        unique case (state_q)
            StIdle: begin
                // Memory has no reset: never grant while it may still be finishing an access.
                if ((bus.p0_req || bus.p1_req) && !bus.mem_clk_stall) begin
                    win_d        = (bus.p0_req && bus.p1_req) ? ~last_grant_q : bus.p1_req;
                    last_grant_d = win_d;
                    addr_d       = win_d ? bus.p1_addr      : bus.p0_addr;
                    wdata_d      = win_d ? bus.p1_wdata     : bus.p0_wdata;
                    we_d         = win_d ? bus.p1_we        : bus.p0_we;
                    mask_d       = win_d ? bus.p1_sign_mask : bus.p0_sign_mask;
                    state_d      = StIssue;
                end
            end
            StIssue: begin
                state_d = StStallHi;
`ifdef DMEM_ARB_TIMEOUT_EN
                wdog_d  = '0;
`endif
            end
            StStallHi: begin
                if (bus.mem_clk_stall) state_d = StStallLo;
            end
            StStallLo: begin
                if (!bus.mem_clk_stall) begin
                    state_d = StResp;
                    cap_d   = we_q ? '0 : bus.mem_read_data;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
`ifdef DMEM_ARB_TIMEOUT_EN
        // A completion seen in the expiry cycle wins over the watchdog.
        if ((state_q == StStallHi || state_q == StStallLo) && state_d != StResp) begin
            wdog_d = wdog_q + 1'b1;
            if (wd_expire) begin
                state_d   = StResp;
                timeout_d = 1'b1;
                cap_d     = '0;
            end
        end
`endif

        mem_rd_d    = (state_d == StIssue) && !we_d;
        mem_wr_d    = (state_d == StIssue) && we_d;
        mem_addr_d  = (state_d == StIssue) ? addr_d  : '0;
        mem_wdata_d = (state_d == StIssue) ? wdata_d : '0;
        mem_mask_d  = (state_d == StIssue) ? mask_d  : '0;
        ack_d[0]    = (state_d == StResp) && !win_q;
        ack_d[1]    = (state_d == StResp) && win_q;
        rdata0_d    = ack_d[0] ? cap_d : '0;
        rdata1_d    = ack_d[1] ? cap_d : '0;
        busy_d      = (state_d != StIdle);
        err_d       = timeout_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            win_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            mask_q       <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_rd_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            mem_mask_q   <= '0;
            ack_q        <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
`ifdef DMEM_ARB_TIMEOUT_EN
            wdog_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            win_q        <= win_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            we_q         <= we_d;
            mask_q       <= mask_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_rd_q     <= mem_rd_d;
            mem_wr_q     <= mem_wr_d;
            mem_mask_q   <= mem_mask_d;
            ack_q        <= ack_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
`ifdef DMEM_ARB_TIMEOUT_EN
            wdog_q       <= wdog_d;
`endif
        end
    end

    assign bus.mem_addr       = mem_addr_q;
    assign bus.mem_write_data = mem_wdata_q;
    assign bus.mem_memread    = mem_rd_q;
    assign bus.mem_memwrite   = mem_wr_q;
    assign bus.mem_sign_mask  = mem_mask_q;
    assign bus.p0_ack         = ack_q[0];
    assign bus.p1_ack         = ack_q[1];
    assign bus.p0_rdata       = rdata0_q;
    assign bus.p1_rdata       = rdata1_q;
    assign bus.busy           = busy_q;
    assign bus.err            = err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: stalling memory model, request-level reference model and an
// ack-driven scoreboard; directed timing cases followed by concurrent random traffic.
`timescale 1ns/1ps
module tb_dmem_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(15)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Requester drive
    logic [1:0]       req = '0;
    logic [1:0]       we = '0;
    logic [1:0][31:0] addr = '0;
    logic [1:0][31:0] wdata = '0;
    logic [1:0][3:0]  mask = '0;
    assign bus.p0_req = req[0];
    assign bus.p0_we = we[0];
    assign bus.p0_addr = addr[0];
    assign bus.p0_wdata = wdata[0];
    assign bus.p0_sign_mask = mask[0];
    assign bus.p1_req = req[1];
    assign bus.p1_we = we[1];
    assign bus.p1_addr = addr[1];
    assign bus.p1_wdata = wdata[1];
    assign bus.p1_sign_mask = mask[1];

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Memory model: sign_mask 4'b0000 = byte store on lane addr[1:0], otherwise full word.
    logic [31:0] dmem [0:4095];
    logic        mem_init = 1'b0;
    logic        mem_stall = 1'b0;
    logic [31:0] mem_rdata = '0;
    int          stall_cnt = 0;
    bit          hold_stall = 1'b0;
    bit          rand_stall = 1'b0;
    assign bus.mem_clk_stall = mem_stall;
    assign bus.mem_read_data = mem_rdata;

    always @(posedge clk) begin
        logic [31:0] cur;
        logic [11:0] wa;
        if (!mem_init) begin
            for (int i = 0; i < 4096; i++) dmem[i] <= '0;
            mem_init <= 1'b1;
        end else if (stall_cnt > 0) begin
            if (!hold_stall) begin
                if (stall_cnt == 1) mem_stall <= 1'b0;
                stall_cnt <= stall_cnt - 1;
            end
        end else if (bus.mem_memread || bus.mem_memwrite) begin
            wa  = bus.mem_addr[13:2];
            cur = dmem[wa];
            if (bus.mem_memwrite) begin
                if (bus.mem_sign_mask == 4'b0000) cur[8*bus.mem_addr[1:0] +: 8] = bus.mem_write_data[7:0];
                else cur = bus.mem_write_data;
                dmem[wa] <= cur;
            end else begin
                mem_rdata <= cur;
            end
            mem_stall <= 1'b1;
            stall_cnt <= rand_stall ? int'($urandom_range(4, 1)) : 2;
        end
    end

    // Reference model: word-addressed contents as seen by completed requests, default 0.
    logic [31:0] ref_mem [int unsigned];

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        int unsigned w = int'(a >> 2);
        return ref_mem.exists(w) ? ref_mem[w] : 32'h0;
    endfunction

    function automatic void ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        logic [31:0] cur = ref_read(a);
        int unsigned sh = 8 * int'(a % 4);
        if (m == 4'b0000) cur = (cur & ~(32'hFF << sh)) | ({24'h0, d[7:0]} << sh);
        else cur = d;
        ref_mem[int'(a >> 2)] = cur;
    endfunction

    // Scoreboard: {err, rdata} per port, pushed at issue, popped on ack.
    logic [32:0] exp0 [$];
    logic [32:0] exp1 [$];
    int          ack_log [$];
    logic        prev_strobe = 1'b0;

    task automatic push_exp(input int p, input logic [32:0] e);
        if (p == 0) exp0.push_back(e);
        else exp1.push_back(e);
    endtask

    task automatic sb_pop(input int p, input logic [31:0] rd);
        logic [32:0] e;
        if ((p == 0 && exp0.size() == 0) || (p == 1 && exp1.size() == 0)) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_ack port %0d: got ack, expected none", p);
        end else begin
            e = (p == 0) ? exp0.pop_front() : exp1.pop_front();
            check(p == 0 ? "p0_rdata" : "p1_rdata", rd, e[31:0]);
            check(p == 0 ? "p0_err" : "p1_err", {31'h0, bus.err}, {31'h0, e[32]});
        end
    endtask

    always @(negedge clk) begin
        logic strobe;
        strobe = bus.mem_memread || bus.mem_memwrite;
        if (!reset) begin
            if (bus.p0_ack) begin ack_log.push_back(0); sb_pop(0, bus.p0_rdata); end
            if (bus.p1_ack) begin ack_log.push_back(1); sb_pop(1, bus.p1_rdata); end
            if (strobe) begin
                check("strobe_one_cycle", {31'h0, prev_strobe}, 32'h0);
                check("strobe_exclusive", {31'h0, bus.mem_memread && bus.mem_memwrite}, 32'h0);
            end
        end
        prev_strobe = strobe;
    end

    function automatic logic ackv(input int p);
        return (p == 0) ? bus.p0_ack : bus.p1_ack;
    endfunction

    task automatic wait_ack(input int p);
        int n = 0;
        do begin @(negedge clk); n++; end while (!ackv(p) && n < 300);
        if (!ackv(p)) begin
            vectors++;
            miscompares++;
            $display("FAIL ack_timeout port %0d: got no ack, expected one within 300 cycles", p);
        end
        @(posedge clk); #1;
        req[p] = 1'b0;
    endtask

    task automatic drive(input int p, input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] m);
        logic [31:0] e = w ? 32'h0 : ref_read(a);
        if (w) ref_write(a, d, m);
        push_exp(p, {1'b0, e});
        we[p] = w; addr[p] = a; wdata[p] = d; mask[p] = m; req[p] = 1'b1;
    endtask

    task automatic do_req(input int p, input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] m);
        drive(p, w, a, d, m);
        wait_ack(p);
    endtask

    // Cycle-accurate observation; cycle 0 is the current cycle with requests already driven.
    int ack0_cyc, ack1_cyc, err_cyc;
    int strobe_cyc [$];
    int busy_at [32];

    task automatic timed_run(input int ncyc, input int hold_at, input bit scramble);
        ack0_cyc = -1; ack1_cyc = -1; err_cyc = -1;
        strobe_cyc.delete();
        for (int k = 0; k < ncyc; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
                if (ack0_cyc >= 0) req[0] = 1'b0;
                if (ack1_cyc >= 0) req[1] = 1'b0;
                if (k == hold_at) hold_stall = 1'b1;
                if (scramble && k == 1) begin
                    addr[0] = 32'h0000_0FF0; we[0] = 1'b1; wdata[0] = $urandom;
                end
            end
            @(negedge clk);
            if (bus.p0_ack && ack0_cyc < 0) ack0_cyc = k;
            if (bus.p1_ack && ack1_cyc < 0) ack1_cyc = k;
            if (bus.err && err_cyc < 0) err_cyc = k;
            if (bus.mem_memread || bus.mem_memwrite) strobe_cyc.push_back(k);
            busy_at[k] = int'(bus.busy);
        end
        @(posedge clk); #1;
        req = '0;
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic rand_port(input int p, input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            logic        w = 1'($urandom_range(1, 0));
            logic [3:0]  m = $urandom_range(1, 0) ? 4'b0010 : 4'b0000;
            logic [31:0] a = base + {24'h0, 8'($urandom_range(255, 0))};
            if (m != 4'b0000 || !w) a[1:0] = 2'b00;
            do_req(p, w, a, $urandom, m);
            repeat ($urandom_range(3, 0)) begin @(posedge clk); #1; end
        end
    endtask

    initial begin
        int quiet;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_busy", {31'h0, bus.busy}, 32'h0);
        check("rst_acks", {30'h0, bus.p1_ack, bus.p0_ack}, 32'h0);
        check("rst_strobes", {30'h0, bus.mem_memwrite, bus.mem_memread}, 32'h0);
        check("rst_err", {31'h0, bus.err}, 32'h0);
        @(posedge clk); #1;

        // Load latency; payload scrambled after grant must be ignored
        do_req(0, 1'b1, 32'h1004, 32'hDEAD_BEEF, 4'b0010);
        drive(0, 1'b0, 32'h1004, 32'h0, 4'b0010);
        timed_run(8, -1, 1'b1);
        check("t1_strobe_count", strobe_cyc.size(), 1);
        if (strobe_cyc.size() > 0) check("t1_strobe_cycle", strobe_cyc[0], 1);
        check("t1_ack_cycle", ack0_cyc, 5);
        check("t1_no_err", err_cyc, -1);

        // Simultaneous requests right after reset: port 0 wins the first tie
        reset_dut();
        drive(0, 1'b0, 32'h1004, 32'h0, 4'b0010);
        drive(1, 1'b0, 32'h1004, 32'h0, 4'b0010);
        timed_run(13, -1, 1'b0);
        check("t2_p0_ack_cycle", ack0_cyc, 5);
        check("t2_p1_issue_cycle", strobe_cyc.size() > 1 ? strobe_cyc[1] : -1, 7);
        check("t2_p1_ack_cycle", ack1_cyc, 11);

        // Both held for four accesses: strict alternation
        ack_log.delete();
        fork
            begin
                do_req(0, 1'b0, 32'h1004, 32'h0, 4'b0010);
                do_req(0, 1'b0, 32'h1004, 32'h0, 4'b0010);
            end
            begin
                do_req(1, 1'b0, 32'h1008, 32'h0, 4'b0010);
                do_req(1, 1'b0, 32'h1008, 32'h0, 4'b0010);
            end
        join
        check("t3_ack_count", ack_log.size(), 4);
        for (int i = 0; i < 4 && i < ack_log.size(); i++) check("t3_grant_order", ack_log[i], i % 2);

        // Byte store through port 1 merges into the word
        do_req(0, 1'b1, 32'h1000, 32'h1122_3344, 4'b0010);
        do_req(1, 1'b1, 32'h1001, 32'h0000_00AB, 4'b0000);
        do_req(0, 1'b0, 32'h1000, 32'h0, 4'b0010);

        // Reset while in STALL_LO with memory still stalled
        drive(0, 1'b0, 32'h1004, 32'h0, 4'b0010);
        repeat (3) begin @(posedge clk); #1; end
        hold_stall = 1'b1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("t5_busy_after_reset", {31'h0, bus.busy}, 32'h0);
        quiet = 0;
        for (int k = 0; k < 8; k++) begin
            if (bus.mem_memread || bus.mem_memwrite || bus.p0_ack) quiet++;
            @(negedge clk);
        end
        check("t5_quiet_while_stalled", quiet, 0);
        @(posedge clk); #1;
        hold_stall = 1'b0;
        wait_ack(0);

`ifdef DMEM_ARB_TIMEOUT_EN
        // Memory never releases the stall
        push_exp(0, {1'b1, 32'h0});
        we[0] = 1'b0; addr[0] = 32'h1004; mask[0] = 4'b0010; req[0] = 1'b1;
        timed_run(20, 2, 1'b0);
        check("t6_ack_cycle", ack0_cyc, 17);
        check("t6_err_cycle", err_cyc, 17);
        check("t6_busy_at_ack", busy_at[17], 1);
        check("t6_busy_after", busy_at[18], 0);
        hold_stall = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
`endif

        // Random concurrent traffic in disjoint regions, random stall lengths
        rand_stall = 1'b1;
        fork
            rand_port(0, 25, 32'h0000_0100);
            rand_port(1, 25, 32'h0000_0800);
        join
        repeat (4) begin @(posedge clk); #1; end
        check("sb_drain", exp0.size() + exp1.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: got no finish, expected finish before 400us");
        $fatal(1);
    end

endmodule
